// File: rtl/hazard_unit_fsm.sv
// hazard_unit_fsm
// Hazard unit for the 5-stage MIPS pipeline. It detects load-use hazards
// and, when branches are resolved in ID, ALU->branch, load->branch and
// MEM-load->branch hazards. A load feeding a branch needs two bubbles, so a
// one-state stall sequencer supplies the second one. The unit also flushes
// IF/ID on a taken branch, freezes on debug halt, and counts every bubble it
// injects in a saturating counter.
module hazard_unit_fsm #(
    parameter int REG_ADDR_W   = 5,
    parameter bit BRANCH_IN_ID = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_halt,
    input  logic [REG_ADDR_W-1:0] i_if_id_rs,
    input  logic [REG_ADDR_W-1:0] i_if_id_rt,
    input  logic                  i_uses_rt,
    input  logic                  i_is_branch,
    input  logic                  i_branch_taken,
    input  logic [REG_ADDR_W-1:0] i_id_ex_wreg,
    input  logic                  i_id_ex_MemRead,
    input  logic                  i_id_ex_RegWrite,
    input  logic [REG_ADDR_W-1:0] i_ex_mem_wreg,
    input  logic                  i_ex_mem_MemRead,
    output logic                  o_PCWrite,
    output logic                  o_if_id_write,
    output logic                  o_control_mux,
    output logic                  o_if_id_flush,
    output logic                  o_stalling,
    output logic [CNT_W-1:0]      o_bubble_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            ex_match;
    logic            mem_match;
    logic            hz_lu;
    logic            hz_ab;
    logic            hz_lb;
    logic            hz_mb;
    logic            stall;
    logic [CNT_W-1:0] bubble_count;

    // Source-operand matches against the EX and MEM destinations; $zero never matches.
    always_comb begin
        ex_match  = (i_id_ex_wreg != '0) &&
                    ((i_id_ex_wreg == i_if_id_rs) ||
                     (i_uses_rt && (i_id_ex_wreg == i_if_id_rt)));
        mem_match = (i_ex_mem_wreg != '0) &&
                    ((i_ex_mem_wreg == i_if_id_rs) ||
                     (i_uses_rt && (i_ex_mem_wreg == i_if_id_rt)));
        hz_lu     = i_id_ex_MemRead && ex_match;
        hz_ab     = BRANCH_IN_ID && i_is_branch && i_id_ex_RegWrite &&
                    !i_id_ex_MemRead && ex_match;
        hz_lb     = BRANCH_IN_ID && i_is_branch && i_id_ex_MemRead && ex_match;
        hz_mb     = BRANCH_IN_ID && i_is_branch && i_ex_mem_MemRead && mem_match;
    end

    // State register; halt freezes the sequencer so a pending bubble survives it.
    always_ff @(posedge i_clock or negedge i_reset) begin
        // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
        if (!i_reset) begin
            state <= IDLE;
        end else if (!i_halt) begin
            state <= state_next;
        end
    end

    // Next-state and raw stall decision; STALL ignores its inputs and always returns to IDLE.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_next = state;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                if (hz_lb) begin
                    stall      = 1'b1;
                    state_next = STALL;
                end else if (hz_lu || hz_ab || hz_mb) begin
                    stall = 1'b1;
                end
            end
            STALL: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pipeline control outputs; reset forces everything off, then halt, then stall.
    always_comb begin
        o_PCWrite     = 1'b0;
        o_if_id_write = 1'b0;
        o_control_mux = 1'b0;
        o_if_id_flush = 1'b0;
        if (i_reset && !i_halt) begin
            o_PCWrite     = !stall;
            o_if_id_write = !stall;
            o_control_mux = stall;
            o_if_id_flush = i_branch_taken && !stall;
        end
        o_stalling     = (state == STALL);
        o_bubble_count = bubble_count;
    end

    // Saturating count of injected bubbles; halt already forces the mux low, so it holds.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            bubble_count <= '0;
        end else if (o_control_mux && (bubble_count != '1)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_fsm.sv
// tb_hazard_unit_fsm
// Directed vectors with hand-computed responses. The driver applies one
// vector per cycle and pushes its expected response into a scoreboard queue;
// a monitor pops and compares on the falling edge. A second instance with
// BRANCH_IN_ID=0 runs on the same inputs and its PC enable is checked too.
module tb_hazard_unit_fsm;

    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          halt = 1'b0;
    logic [AW-1:0] rs = '0, rt = '0, ex_wreg = '0, mem_wreg = '0;
    logic          uses_rt = 1'b0, is_br = 1'b0, taken = 1'b0;
    logic          ex_mr = 1'b0, ex_rw = 1'b0, mem_mr = 1'b0;

    logic          pcw, ifw, mux, fl, stl;
    logic [CW-1:0] cnt;
    logic          nb_pcw, nb_ifw, nb_mux, nb_fl, nb_stl;
    logic [CW-1:0] nb_cnt;

    typedef struct {
        int          id;
        logic        pcw;
        logic        ifw;
        logic        mux;
        logic        fl;
        logic        stl;
        logic [15:0] cnt;
        logic        nb_pcw;
    } exp_t;

    exp_t sb[$];
    int   vec_id      = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit_fsm #(.REG_ADDR_W(AW), .BRANCH_IN_ID(1'b1), .CNT_W(CW)) dut (
        .i_clock(clk), .i_reset(rst), .i_halt(halt),
        .i_if_id_rs(rs), .i_if_id_rt(rt), .i_uses_rt(uses_rt),
        .i_is_branch(is_br), .i_branch_taken(taken),
        .i_id_ex_wreg(ex_wreg), .i_id_ex_MemRead(ex_mr), .i_id_ex_RegWrite(ex_rw),
        .i_ex_mem_wreg(mem_wreg), .i_ex_mem_MemRead(mem_mr),
        .o_PCWrite(pcw), .o_if_id_write(ifw), .o_control_mux(mux),
        .o_if_id_flush(fl), .o_stalling(stl), .o_bubble_count(cnt)
    );

    hazard_unit_fsm #(.REG_ADDR_W(AW), .BRANCH_IN_ID(1'b0), .CNT_W(CW)) dut_nb (
        .i_clock(clk), .i_reset(rst), .i_halt(halt),
        .i_if_id_rs(rs), .i_if_id_rt(rt), .i_uses_rt(uses_rt),
        .i_is_branch(is_br), .i_branch_taken(taken),
        .i_id_ex_wreg(ex_wreg), .i_id_ex_MemRead(ex_mr), .i_id_ex_RegWrite(ex_rw),
        .i_ex_mem_wreg(mem_wreg), .i_ex_mem_MemRead(mem_mr),
        .o_PCWrite(nb_pcw), .o_if_id_write(nb_ifw), .o_control_mux(nb_mux),
        .o_if_id_flush(nb_fl), .o_stalling(nb_stl), .o_bubble_count(nb_cnt)
    );

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            miscompares++;
            $display("FAIL v%0d %s: got %0h want %0h", id, name, act, want);
        end
    endtask

    // Drive one vector just after the rising edge and queue its expected response.
    task automatic vec(input logic r, input logic h,
                       input int v_rs, input int v_rt, input logic v_urt,
                       input logic v_br, input logic v_tk,
                       input int v_exw, input logic v_exmr, input logic v_exrw,
                       input int v_memw, input logic v_memmr,
                       input logic e_pcw, input logic e_ifw, input logic e_mux,
                       input logic e_fl, input logic e_stl, input int e_cnt,
                       input logic e_nb_pcw);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        halt     = h;
        rs       = AW'(v_rs);
        rt       = AW'(v_rt);
        uses_rt  = v_urt;
        is_br    = v_br;
        taken    = v_tk;
        ex_wreg  = AW'(v_exw);
        ex_mr    = v_exmr;
        ex_rw    = v_exrw;
        mem_wreg = AW'(v_memw);
        mem_mr   = v_memmr;
        e.id     = vec_id;
        e.pcw    = e_pcw;
        e.ifw    = e_ifw;
        e.mux    = e_mux;
        e.fl     = e_fl;
        e.stl    = e_stl;
        e.cnt    = 16'(e_cnt);
        e.nb_pcw = e_nb_pcw;
        sb.push_back(e);
        vec_id++;
    endtask

    // Monitor: compare the DUT response mid-cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                check("PCWrite",      e.id, 32'(pcw),    32'(e.pcw));
                check("if_id_write",  e.id, 32'(ifw),    32'(e.ifw));
                check("control_mux",  e.id, 32'(mux),    32'(e.mux));
                check("if_id_flush",  e.id, 32'(fl),     32'(e.fl));
                check("stalling",     e.id, 32'(stl),    32'(e.stl));
                check("bubble_count", e.id, 32'(cnt),    32'(e.cnt));
                check("nb_PCWrite",   e.id, 32'(nb_pcw), 32'(e.nb_pcw));
            end
        end
    end

    initial begin
        int budget;
        //   rst h  rs rt urt br tk exw mr rw memw mm | pcw ifw mux fl stl cnt nb
        vec(0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0); // v0 in reset
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 0, 1); // v1 idle
        vec(1, 0, 10, 0, 0, 0, 0, 10, 1, 1,  0, 0,   0, 0, 1, 0, 0, 0, 0); // v2 load-use
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 1, 1); // v3
        vec(1, 0,  7, 0, 0, 1, 0,  7, 1, 1,  0, 0,   0, 0, 1, 0, 0, 1, 0); // v4 load->branch
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 1, 0, 1, 2, 1); // v5 second bubble
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 3, 1); // v6
        vec(1, 0,  3, 4, 1, 1, 0,  4, 0, 1,  0, 0,   0, 0, 1, 0, 0, 3, 1); // v7 ALU->branch on rt
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 4, 1); // v8
        vec(1, 0, 12, 0, 0, 1, 0,  0, 0, 0, 12, 1,   0, 0, 1, 0, 0, 4, 1); // v9 MEM load->branch
        vec(1, 0,  0, 0, 0, 0, 0,  0, 1, 0,  0, 0,   1, 1, 0, 0, 0, 5, 1); // v10 $zero never matches
        vec(1, 0,  1, 9, 0, 0, 0,  9, 1, 0,  0, 0,   1, 1, 0, 0, 0, 5, 1); // v11 rt ignored
        vec(1, 0,  1, 9, 1, 0, 0,  9, 1, 0,  0, 0,   0, 0, 1, 0, 0, 5, 0); // v12 rt used
        vec(1, 0,  0, 0, 0, 0, 1,  0, 0, 0,  0, 0,   1, 1, 0, 1, 0, 6, 1); // v13 taken -> flush
        vec(1, 0, 10, 0, 0, 0, 1, 10, 1, 0,  0, 0,   0, 0, 1, 0, 0, 6, 0); // v14 flush masked by stall
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 7, 1); // v15
        vec(1, 0,  7, 0, 0, 1, 0,  7, 1, 0,  0, 0,   0, 0, 1, 0, 0, 7, 0); // v16 enter STALL
        vec(1, 1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 1, 8, 0); // v17 halt in STALL
        vec(1, 1,  0, 0, 0, 0, 1,  0, 0, 0,  0, 0,   0, 0, 0, 0, 1, 8, 0); // v18 halt, taken ignored
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 1, 0, 1, 8, 1); // v19 stall resumes
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 9, 1); // v20
        vec(1, 0,  7, 0, 0, 1, 0,  7, 1, 0,  0, 0,   0, 0, 1, 0, 0, 9, 0); // v21 enter STALL
        vec(0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0); // v22 reset mid-STALL
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 0, 1); // v23 back in IDLE
        vec(1, 1, 10, 0, 0, 0, 0, 10, 1, 0,  0, 0,   0, 0, 0, 0, 0, 0, 0); // v24 halt masks hazard
        vec(1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,   1, 1, 0, 0, 0, 0, 1); // v25 count held

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
